// File: rtl/sram_write_arbiter_if.sv
// Bundle for four SRAM write requesters and the shared registered write port.
// The arbiter uses the slave modport; requesters drive through master.
interface sram_write_arbiter_if #(
    parameter int DATA_BITS = 8,
    parameter int ADDR_BITS = 4
);
    logic [3:0]             req;
    logic [4*ADDR_BITS-1:0] req_addr;
    logic [4*DATA_BITS-1:0] req_data;
    logic [3:0]             ack;
    logic                   write_en;
    logic [ADDR_BITS-1:0]   write_addr;
    logic [DATA_BITS-1:0]   write_data;
    logic [1:0]             grant_id;
    logic                   busy;
    logic [7:0]             conflict_count;

    modport master (
        output req, req_addr, req_data,
        input  ack, write_en, write_addr, write_data,
        input  grant_id, busy, conflict_count
    );

    modport slave (
        input  req, req_addr, req_data,
        output ack, write_en, write_addr, write_data,
        output grant_id, busy, conflict_count
    );
endinterface

// File: rtl/sram_write_arbiter.sv
// Four-way round-robin SRAM write arbiter with bounded bursts per grant.
// Optional contention counter enabled by ARB_CONFLICT_COUNT_EN.
module sram_write_arbiter #(
    parameter int DATA_BITS = 8,
    parameter int ADDR_BITS = 4,
    parameter int BURST_MAX = 4
) (
    input  logic                clk,
    input  logic                reset,
    sram_write_arbiter_if.slave bus
);
    typedef enum logic {IDLE, WRITE} state_t;

    localparam logic [3:0] BMAX = 4'(BURST_MAX);

    state_t               state_q, state_d;
    logic [1:0]           owner_q, owner_d;
    logic                 owner_vld_q, owner_vld_d;
    logic [1:0]           rr_ptr_q, rr_ptr_d;
    logic [3:0]           burst_cnt_q, burst_cnt_d;
    logic [3:0]           ack_q, ack_d;
    logic                 write_en_q, write_en_d;
    logic [ADDR_BITS-1:0] write_addr_q, write_addr_d;
    logic [DATA_BITS-1:0] write_data_q, write_data_d;

    logic [3:0] elig;
    logic [1:0] win;
    logic       win_vld;
    logic       keep;
    logic       grant;
    logic [1:0] sel;

    assign elig = bus.req & ~ack_q;

    always_comb begin
        win     = 2'd0;
        win_vld = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (!win_vld && elig[rr_ptr_q + 2'(k)]) begin
                win     = rr_ptr_q + 2'(k);
                win_vld = 1'b1;
            end
        end
    end

    // Current owner continues only while under its burst allowance
    assign keep = owner_vld_q && elig[owner_q] && (burst_cnt_q < BMAX);

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        owner_vld_d  = owner_vld_q;
        rr_ptr_d     = rr_ptr_q;
        burst_cnt_d  = burst_cnt_q;
        ack_d        = 4'b0000;
        write_en_d   = 1'b0;
        write_addr_d = write_addr_q;
        write_data_d = write_data_q;
        grant        = 1'b0;
        sel          = owner_q;
        unique case (state_q)
            IDLE: begin
                if (keep) begin
                    grant       = 1'b1;
                    sel         = owner_q;
                    burst_cnt_d = burst_cnt_q + 4'd1;
                end else if (win_vld) begin
                    grant       = 1'b1;
                    sel         = win;
                    owner_d     = win;
                    owner_vld_d = 1'b1;
                    burst_cnt_d = 4'd1;
                    rr_ptr_d    = win + 2'd1;
                end else begin
                    owner_vld_d = 1'b0;
                    burst_cnt_d = 4'd0;
                end
                if (grant) begin
                    state_d      = WRITE;
                    write_en_d   = 1'b1;
                    ack_d[sel]   = 1'b1;
                    write_addr_d = bus.req_addr[int'(sel)*ADDR_BITS +: ADDR_BITS];
                    write_data_d = bus.req_data[int'(sel)*DATA_BITS +: DATA_BITS];
                end
            end
            WRITE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            owner_q      <= 2'd0;
            owner_vld_q  <= 1'b0;
            rr_ptr_q     <= 2'd0;
            burst_cnt_q  <= 4'd0;
            ack_q        <= 4'b0000;
            write_en_q   <= 1'b0;
            write_addr_q <= '0;
            write_data_q <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            owner_vld_q  <= owner_vld_d;
            rr_ptr_q     <= rr_ptr_d;
            burst_cnt_q  <= burst_cnt_d;
            ack_q        <= ack_d;
            write_en_q   <= write_en_d;
            write_addr_q <= write_addr_d;
            write_data_q <= write_data_d;
        end
    end

`ifdef ARB_CONFLICT_COUNT_EN
    logic [7:0] conflict_q, conflict_d;
    logic [2:0] n_elig;

    always_comb begin
        n_elig = {2'b00, elig[0]} + {2'b00, elig[1]}
               + {2'b00, elig[2]} + {2'b00, elig[3]};
        conflict_d = conflict_q;
        if (state_q == IDLE && n_elig >= 3'd2 && conflict_q != 8'hFF) begin
            conflict_d = conflict_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            conflict_q <= 8'd0;
        end else begin
            conflict_q <= conflict_d;
        end
    end

    assign bus.conflict_count = conflict_q;
`else
    assign bus.conflict_count = 8'd0;
`endif

    assign bus.ack        = ack_q;
    assign bus.write_en   = write_en_q;
    assign bus.write_addr = write_addr_q;
    assign bus.write_data = write_data_q;
    assign bus.grant_id   = owner_q;
    assign bus.busy       = owner_vld_q;
endmodule

// File: tb/tb_sram_write_arbiter.sv
// Directed bench for sram_write_arbiter: a BURST_MAX=4 instance and a
// BURST_MAX=1 instance share clock and reset.
module tb_sram_write_arbiter;
    logic clk;
    logic reset;
    int   total;
    int   bad;

    sram_write_arbiter_if #(.DATA_BITS(8), .ADDR_BITS(4)) bus_a ();
    sram_write_arbiter_if #(.DATA_BITS(8), .ADDR_BITS(4)) bus_b ();

    sram_write_arbiter #(.DATA_BITS(8), .ADDR_BITS(4), .BURST_MAX(4)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    sram_write_arbiter #(.DATA_BITS(8), .ADDR_BITS(4), .BURST_MAX(1)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset          = 1'b0;
        bus_a.req      = 4'b0000;
        bus_a.req_addr = '0;
        bus_a.req_data = '0;
        bus_b.req      = 4'b0000;
        bus_b.req_addr = '0;
        bus_b.req_data = '0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        bus_a.req      = 4'b1111;
        bus_a.req_addr = 16'hFFFF;
        bus_a.req_data = 32'hFFFF_FFFF;
        tick();
        tick();
        total++;
        if (bus_a.ack !== 4'b0000) begin
            bad++; $display("FAIL reset_ack got=%b exp=0000", bus_a.ack);
        end
        total++;
        if (bus_a.write_en !== 1'b0) begin
            bad++; $display("FAIL reset_we got=%b exp=0", bus_a.write_en);
        end
        total++;
        if (bus_a.write_addr !== 4'h0 || bus_a.write_data !== 8'h00) begin
            bad++; $display("FAIL reset_addr_data got=%h/%h exp=0/00",
                            bus_a.write_addr, bus_a.write_data);
        end
        total++;
        if (bus_a.grant_id !== 2'd0 || bus_a.busy !== 1'b0) begin
            bad++; $display("FAIL reset_grant_busy got=%0d/%b exp=0/0",
                            bus_a.grant_id, bus_a.busy);
        end
        total++;
        if (bus_a.conflict_count !== 8'd0) begin
            bad++; $display("FAIL reset_cc got=%0d exp=0", bus_a.conflict_count);
        end
    endtask

    task automatic test_single();
        logic exp_we;
        do_reset();
        bus_a.req                = 4'b0001;
        bus_a.req_addr[3:0]      = 4'd3;
        bus_a.req_data[7:0]      = 8'hA5;
        reset = 1'b1;
        for (int t = 1; t <= 11; t++) begin
            tick();
            exp_we = (t % 2) == 1;
            total++;
            if (bus_a.write_en !== exp_we) begin
                bad++; $display("FAIL single_we t=%0d got=%b exp=%b", t, bus_a.write_en, exp_we);
            end
            total++;
            if (bus_a.ack !== (exp_we ? 4'b0001 : 4'b0000)) begin
                bad++; $display("FAIL single_ack t=%0d got=%b exp=%b", t, bus_a.ack,
                                exp_we ? 4'b0001 : 4'b0000);
            end
            total++;
            if (bus_a.write_addr !== 4'd3 || bus_a.write_data !== 8'hA5) begin
                bad++; $display("FAIL single_addr_data t=%0d got=%h/%h exp=3/a5",
                                t, bus_a.write_addr, bus_a.write_data);
            end
            total++;
            if (bus_a.busy !== 1'b1) begin
                bad++; $display("FAIL single_busy t=%0d got=%b exp=1", t, bus_a.busy);
            end
        end
        bus_a.req = 4'b0000;
        tick();
        total++;
        if (bus_a.write_en !== 1'b0 || bus_a.busy !== 1'b1) begin
            bad++; $display("FAIL release_idle got=we%b/busy%b exp=we0/busy1",
                            bus_a.write_en, bus_a.busy);
        end
        tick();
        total++;
        if (bus_a.write_en !== 1'b0 || bus_a.busy !== 1'b0) begin
            bad++; $display("FAIL released got=we%b/busy%b exp=we0/busy0",
                            bus_a.write_en, bus_a.busy);
        end
        total++;
        if (bus_a.write_addr !== 4'd3 || bus_a.write_data !== 8'hA5
            || bus_a.grant_id !== 2'd0) begin
            bad++; $display("FAIL hold_after_release got=%h/%h/%0d exp=3/a5/0",
                            bus_a.write_addr, bus_a.write_data, bus_a.grant_id);
        end
    endtask

    task automatic test_rr_burst1();
        logic [3:0] seq [0:9];
        logic [7:0] exp_d;
        seq = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                4'b0000, 4'b1000, 4'b0000, 4'b0001, 4'b0000};
        do_reset();
        bus_b.req      = 4'b1111;
        bus_b.req_addr = 16'h3210;
        bus_b.req_data = 32'h1312_1110;
        reset = 1'b1;
        for (int t = 0; t < 10; t++) begin
            tick();
            total++;
            if (bus_b.ack !== seq[t]) begin
                bad++; $display("FAIL rr_ack t=%0d got=%b exp=%b", t + 1, bus_b.ack, seq[t]);
            end
            if (seq[t] != 4'b0000) begin
                exp_d = 8'h10 + 8'(t / 2 % 4);
                total++;
                if (bus_b.write_data !== exp_d) begin
                    bad++; $display("FAIL rr_data t=%0d got=%h exp=%h",
                                    t + 1, bus_b.write_data, exp_d);
                end
            end
        end
    endtask

    task automatic test_burst4();
        int         w;
        logic [1:0] own;
        logic [3:0] exp_ack;
        do_reset();
        bus_a.req            = 4'b0101;
        bus_a.req_addr[3:0]  = 4'd1;
        bus_a.req_addr[11:8] = 4'd2;
        bus_a.req_data[7:0]  = 8'h0A;
        bus_a.req_data[23:16] = 8'h2A;
        reset = 1'b1;
        for (int t = 1; t <= 24; t++) begin
            tick();
            w       = (t - 1) / 2;
            own     = ((w / 4) % 2 == 0) ? 2'd0 : 2'd2;
            exp_ack = (t % 2 == 1) ? (4'b0001 << own) : 4'b0000;
            total++;
            if (bus_a.ack !== exp_ack) begin
                bad++; $display("FAIL burst_ack t=%0d got=%b exp=%b", t, bus_a.ack, exp_ack);
            end
            total++;
            if (bus_a.busy !== 1'b1) begin
                bad++; $display("FAIL burst_busy t=%0d got=%b exp=1", t, bus_a.busy);
            end
            if (t % 2 == 1) begin
                total++;
                if (bus_a.grant_id !== own
                    || bus_a.write_addr !== ((own == 2'd0) ? 4'd1 : 4'd2)) begin
                    bad++; $display("FAIL burst_grant t=%0d got=%0d/%h exp=%0d",
                                    t, bus_a.grant_id, bus_a.write_addr, own);
                end
            end
        end
    endtask

    task automatic test_drop();
        do_reset();
        bus_a.req             = 4'b1010;
        bus_a.req_addr[7:4]   = 4'd7;
        bus_a.req_addr[15:12] = 4'd9;
        bus_a.req_data[15:8]  = 8'h11;
        bus_a.req_data[31:24] = 8'h33;
        reset = 1'b1;
        tick();
        total++;
        if (bus_a.ack !== 4'b0010 || bus_a.write_addr !== 4'd7) begin
            bad++; $display("FAIL drop_first got=%b/%h exp=0010/7", bus_a.ack, bus_a.write_addr);
        end
        bus_a.req = 4'b1000;
        tick();
        total++;
        if (bus_a.write_en !== 1'b0 || bus_a.busy !== 1'b1) begin
            bad++; $display("FAIL drop_gap got=we%b/busy%b exp=we0/busy1",
                            bus_a.write_en, bus_a.busy);
        end
        tick();
        total++;
        if (bus_a.ack !== 4'b1000 || bus_a.grant_id !== 2'd3
            || bus_a.write_data !== 8'h33 || bus_a.busy !== 1'b1) begin
            bad++; $display("FAIL drop_switch got=%b/%0d/%h/%b exp=1000/3/33/1",
                            bus_a.ack, bus_a.grant_id, bus_a.write_data, bus_a.busy);
        end
    endtask

    task automatic test_reset_abort();
        do_reset();
        bus_a.req             = 4'b0100;
        bus_a.req_addr[11:8]  = 4'd5;
        bus_a.req_data[23:16] = 8'h55;
        bus_a.req_addr[15:12] = 4'd6;
        bus_a.req_data[31:24] = 8'h66;
        reset = 1'b1;
        tick();
        total++;
        if (bus_a.ack !== 4'b0100) begin
            bad++; $display("FAIL abort_pre got=%b exp=0100", bus_a.ack);
        end
        reset     = 1'b0;
        bus_a.req = 4'b1100;
        #1;
        total++;
        if (bus_a.ack !== 4'b0000 || bus_a.write_en !== 1'b0 || bus_a.busy !== 1'b0
            || bus_a.write_addr !== 4'd0 || bus_a.write_data !== 8'd0
            || bus_a.grant_id !== 2'd0) begin
            bad++; $display("FAIL abort_async got=%b/%b/%b/%h/%h/%0d exp=all zero",
                            bus_a.ack, bus_a.write_en, bus_a.busy, bus_a.write_addr,
                            bus_a.write_data, bus_a.grant_id);
        end
        tick();
        reset = 1'b1;
        tick();
        total++;
        if (bus_a.ack !== 4'b0100 || bus_a.write_addr !== 4'd5
            || bus_a.write_data !== 8'h55 || bus_a.grant_id !== 2'd2) begin
            bad++; $display("FAIL abort_retry got=%b/%h/%h/%0d exp=0100/5/55/2",
                            bus_a.ack, bus_a.write_addr, bus_a.write_data, bus_a.grant_id);
        end
    endtask

    task automatic test_conflict();
        logic [7:0] exp_mid;
        logic [7:0] exp_end;
`ifdef ARB_CONFLICT_COUNT_EN
        exp_mid = 8'd10;
        exp_end = 8'd255;
`else
        exp_mid = 8'd0;
        exp_end = 8'd0;
`endif
        do_reset();
        bus_a.req = 4'b0011;
        reset = 1'b1;
        for (int t = 0; t < 20; t++) tick();
        total++;
        if (bus_a.conflict_count !== exp_mid) begin
            bad++; $display("FAIL cc_mid got=%0d exp=%0d", bus_a.conflict_count, exp_mid);
        end
        for (int t = 20; t < 600; t++) tick();
        total++;
        if (bus_a.conflict_count !== exp_end) begin
            bad++; $display("FAIL cc_sat got=%0d exp=%0d", bus_a.conflict_count, exp_end);
        end
        reset = 1'b0;
        #1;
        total++;
        if (bus_a.conflict_count !== 8'd0) begin
            bad++; $display("FAIL cc_reset got=%0d exp=0", bus_a.conflict_count);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_single();
        test_rr_burst1();
        test_burst4();
        test_drop();
        test_reset_abort();
        test_conflict();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
